// File: rtl/hubris_io_pkg.sv
// Shared definitions for the Hubris console output path: serializer states
// and 8N1 framing constants.
package hubris_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_e;

    localparam int   UART_FRAME_BITS = 10;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with a separate occupancy counter and a sticky
// overflow flag for pushes that arrive while the buffer is full.
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               pushData_i,
    input  logic                     pop_i,
    output logic [7:0]               popData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          pushOk;
    logic          popOk;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign popData_o  = mem_q[rdPtr_q];

    // A full buffer rejects the push even when a pop frees a slot on the same edge.
    assign pushOk = push_i && !full_o;
    assign popOk  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
            if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_i && full_o) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/io_output_uart_tx.sv
// Console output port: byte FIFO drained by an 8N1 UART serializer that
// chains queued frames back to back without an idle gap.
module io_output_uart_tx #(
    parameter int OUTPUT_BUFFER_BYTE_SIZE = 64,
    parameter int CLKS_PER_BIT            = 54
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [7:0]                             wr_byte,
    output logic                                   full,
    output logic [$clog2(OUTPUT_BUFFER_BYTE_SIZE):0] count,
    output logic                                   overflow,
    output logic                                   busy,
    output logic                                   io_output_tx
);
    import hubris_io_pkg::*;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(UART_DATA_BITS - 1);

    txState_e      state_q;
    logic [BW-1:0] bitCnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;

    logic          fifoEmpty;
    logic [7:0]    popData;
    logic          bitDone;
    logic          pop;

    byte_fifo #(
        .DEPTH(OUTPUT_BUFFER_BYTE_SIZE)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (wr_en),
        .pushData_i (wr_byte),
        .pop_i      (pop),
        .popData_o  (popData),
        .full_o     (full),
        .empty_o    (fifoEmpty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    assign bitDone = (bitCnt_q == LAST_TICK);

    // Popping on the final stop tick lets the next start bit follow immediately.
    assign pop = !fifoEmpty && ((state_q == IDLE) || (state_q == STOP && bitDone));

    assign io_output_tx = tx_q;
    assign busy         = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bitCnt_q <= '0;
                    tx_q     <= UART_IDLE_LEVEL;
                    if (pop) begin
                        shreg_q <= popData;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bitDone) begin
                        bitCnt_q <= '0;
                        idx_q    <= '0;
                        tx_q     <= shreg_q[0];
                        state_q  <= DATA;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        bitCnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            tx_q    <= UART_IDLE_LEVEL;
                            state_q <= STOP;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shreg_q <= shreg_q >> 1;
                            tx_q    <= shreg_q[1];
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        bitCnt_q <= '0;
                        if (pop) begin
                            shreg_q <= popData;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
